// File: rtl/aurora_chan_regs.sv
// Per-channel control/status register bank for the Aurora RFNoC block.
// Each channel owns a 2**CHAN_ADDR_W byte region starting at BASE_ADDR.
// The region holds TX start/stop strobes, the stop policy, a 64-bit
// start-timestamp FIFO that is popped by the TX datapath, and a
// saturating counter of pushes that were dropped because the FIFO was full.
module aurora_chan_regs #(
   parameter int unsigned NUM_CHAN      = 2,
   parameter int unsigned CHAN_ADDR_W   = 6,
   parameter int unsigned BASE_ADDR     = 64,
   parameter int unsigned TS_DEPTH_LOG2 = 5
) (
   input  logic                     ctrlport_clk,
   input  logic                     ctrlport_rst_n,
   input  logic                     s_ctrlport_req_wr,
   input  logic                     s_ctrlport_req_rd,
   input  logic [19:0]              s_ctrlport_req_addr,
   input  logic [31:0]              s_ctrlport_req_data,
   output logic                     s_ctrlport_resp_ack,
   output logic [31:0]              s_ctrlport_resp_data,
   output logic [NUM_CHAN-1:0]      tx_start,
   output logic [NUM_CHAN-1:0]      tx_stop,
   output logic [NUM_CHAN-1:0]      stop_policy,
   output logic [NUM_CHAN-1:0]      ts_valid,
   output logic [64*NUM_CHAN-1:0]   ts_data,
   input  logic [NUM_CHAN-1:0]      ts_ready
);

   localparam int unsigned L     = TS_DEPTH_LOG2;
   localparam int unsigned DEPTH = 1 << TS_DEPTH_LOG2;

   localparam logic [31:0] REGION_LO = 32'(BASE_ADDR);
   localparam logic [31:0] REGION_HI = 32'(BASE_ADDR + (NUM_CHAN << CHAN_ADDR_W));

   localparam logic [CHAN_ADDR_W-1:0] OFF_TX_CTRL = CHAN_ADDR_W'('h00);
   localparam logic [CHAN_ADDR_W-1:0] OFF_TS_LOW  = CHAN_ADDR_W'('h04);
   localparam logic [CHAN_ADDR_W-1:0] OFF_TS_HIGH = CHAN_ADDR_W'('h08);
   localparam logic [CHAN_ADDR_W-1:0] OFF_POLICY  = CHAN_ADDR_W'('h0C);
   localparam logic [CHAN_ADDR_W-1:0] OFF_Q_STS   = CHAN_ADDR_W'('h10);
   localparam logic [CHAN_ADDR_W-1:0] OFF_Q_CTRL  = CHAN_ADDR_W'('h14);
   localparam logic [CHAN_ADDR_W-1:0] OFF_OVF_CTR = CHAN_ADDR_W'('h18);

   localparam logic [15:0] DEPTH_FIELD = 16'(DEPTH);

   // Address decode shared by all channels
   logic [31:0]             addr_ext;
   logic [31:0]             rel_addr;
   logic [31:0]             chan_idx;
   logic                    in_range;
   logic [CHAN_ADDR_W-1:0]  off;

   assign addr_ext = {12'd0, s_ctrlport_req_addr};
   assign rel_addr = addr_ext - REGION_LO;
   assign chan_idx = rel_addr >> CHAN_ADDR_W;
   assign in_range = (addr_ext >= REGION_LO) && (addr_ext < REGION_HI);
   assign off      = s_ctrlport_req_addr[CHAN_ADDR_W-1:0];

   logic [32*NUM_CHAN-1:0]  chan_rdata;

   for (genvar n = 0; n < NUM_CHAN; n++) begin : g_chan
      logic              sel;
      logic              wr_sel;
      logic              push;
      logic              flush;
      logic              pop;
      logic              full;
      logic              empty;
      logic              push_acc;
      logic              ovf_inc;
      logic              ovf_clr;
      logic [L:0]        fill;
      logic [L:0]        wptr_q, wptr_d;
      logic [L:0]        rptr_q, rptr_d;
      logic [31:0]       shadow_q, shadow_d;
      logic [31:0]       ovf_q, ovf_d;
      logic              pol_q, pol_d;
      logic              start_q, start_d;
      logic              stop_q, stop_d;
      logic [63:0]       mem_q [DEPTH];
      logic [31:0]       rdata;

      assign sel    = in_range && (chan_idx == 32'(n));
      assign wr_sel = sel && s_ctrlport_req_wr;

      assign push    = wr_sel && (off == OFF_TS_HIGH);
      assign flush   = wr_sel && (off == OFF_Q_CTRL) && s_ctrlport_req_data[0];
      assign ovf_clr = wr_sel && (off == OFF_OVF_CTR);

      assign empty = (wptr_q == rptr_q);
      assign full  = (wptr_q[L] != rptr_q[L]) && (wptr_q[L-1:0] == rptr_q[L-1:0]);
      assign fill  = wptr_q - rptr_q;
      assign pop   = !empty && ts_ready[n];

      // A flush discards a coincident push outright, so it is neither stored nor counted
      assign push_acc = push && !flush && (!full || pop);
      assign ovf_inc  = push && !flush && full && !pop;

      // Next-state for queue pointers, shadow, counter, policy and strobes
      always_comb begin
         wptr_d   = wptr_q;
         rptr_d   = rptr_q;
         shadow_d = shadow_q;
         ovf_d    = ovf_q;
         pol_d    = pol_q;
         start_d  = 1'b0;
         stop_d   = 1'b0;

         if (pop)      rptr_d = rptr_q + 1'b1;
         if (push_acc) wptr_d = wptr_q + 1'b1;
         // Flush after any pop: the handshake completes, then the queue reads empty
         if (flush)    rptr_d = wptr_q;

         if (wr_sel && (off == OFF_TS_LOW)) shadow_d = s_ctrlport_req_data;
         if (wr_sel && (off == OFF_POLICY)) pol_d    = s_ctrlport_req_data[0];

         if (ovf_clr)                   ovf_d = '0;
         else if (ovf_inc && ovf_q != '1) ovf_d = ovf_q + 1'b1;

         if (wr_sel && (off == OFF_TX_CTRL)) begin
            stop_d  = s_ctrlport_req_data[1];
            start_d = s_ctrlport_req_data[0] && !s_ctrlport_req_data[1];
         end
      end

      // Channel state registers
      always_ff @(posedge ctrlport_clk or negedge ctrlport_rst_n) begin
         if (!ctrlport_rst_n) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            shadow_q <= '0;
            ovf_q    <= '0;
            pol_q    <= 1'b0;
            start_q  <= 1'b0;
            stop_q   <= 1'b0;
         end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            shadow_q <= shadow_d;
            ovf_q    <= ovf_d;
            pol_q    <= pol_d;
            start_q  <= start_d;
            stop_q   <= stop_d;
         end
      end

      // Timestamp storage; contents only matter while the pointers say so
      always_ff @(posedge ctrlport_clk) begin
         if (push_acc) mem_q[wptr_q[L-1:0]] <= {s_ctrlport_req_data, shadow_q};
      end

      // Readable registers of this channel
      always_comb begin
         rdata = '0;
         if (sel) begin
            case (off)
               OFF_POLICY:  rdata = {31'd0, pol_q};
               OFF_Q_STS:   rdata = {DEPTH_FIELD, 16'(fill)};
               OFF_OVF_CTR: rdata = ovf_q;
               default:     rdata = '0;
            endcase
         end
      end

      assign chan_rdata[32*n +: 32] = rdata;
      assign tx_start[n]            = start_q;
      assign tx_stop[n]             = stop_q;
      assign stop_policy[n]         = pol_q;
      assign ts_valid[n]            = !empty;
      assign ts_data[64*n +: 64]    = empty ? 64'd0 : mem_q[rptr_q[L-1:0]];
   end

   logic        ack_q, ack_d;
   logic [31:0] resp_q, resp_d;

   // Merge channel read data; writes and unmapped reads return zero
   always_comb begin
      ack_d  = s_ctrlport_req_wr || s_ctrlport_req_rd;
      resp_d = '0;
      if (s_ctrlport_req_rd && !s_ctrlport_req_wr) begin
         for (int unsigned i = 0; i < NUM_CHAN; i++) begin
            resp_d = resp_d | chan_rdata[32*i +: 32];
         end
      end
   end

   // Response registers: every request is acknowledged one cycle later
   always_ff @(posedge ctrlport_clk or negedge ctrlport_rst_n) begin
      if (!ctrlport_rst_n) begin
         ack_q  <= 1'b0;
         resp_q <= '0;
      end else begin
         ack_q  <= ack_d;
         resp_q <= resp_d;
      end
   end

   assign s_ctrlport_resp_ack  = ack_q;
   assign s_ctrlport_resp_data = resp_q;

endmodule

// File: tb/tb_aurora_chan_regs.sv
// Directed self-checking bench for aurora_chan_regs (2 channels, 32-entry queues).
module tb_aurora_chan_regs;

   logic         clk;
   logic         rst_n;
   logic         req_wr;
   logic         req_rd;
   logic [19:0]  req_addr;
   logic [31:0]  req_data;
   logic         resp_ack;
   logic [31:0]  resp_data;
   logic [1:0]   tx_start;
   logic [1:0]   tx_stop;
   logic [1:0]   stop_policy;
   logic [1:0]   ts_valid;
   logic [127:0] ts_data;
   logic [1:0]   ts_ready;

   int errors = 0;
   int checks = 0;

   aurora_chan_regs #(
      .NUM_CHAN      (2),
      .CHAN_ADDR_W   (6),
      .BASE_ADDR     (64),
      .TS_DEPTH_LOG2 (5)
   ) dut (
      .ctrlport_clk         (clk),
      .ctrlport_rst_n       (rst_n),
      .s_ctrlport_req_wr    (req_wr),
      .s_ctrlport_req_rd    (req_rd),
      .s_ctrlport_req_addr  (req_addr),
      .s_ctrlport_req_data  (req_data),
      .s_ctrlport_resp_ack  (resp_ack),
      .s_ctrlport_resp_data (resp_data),
      .tx_start             (tx_start),
      .tx_stop              (tx_stop),
      .stop_policy          (stop_policy),
      .ts_valid             (ts_valid),
      .ts_data              (ts_data),
      .ts_ready             (ts_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One bus request per call, issued at a falling edge; consecutive calls are back-to-back
   task automatic bus(input logic w, input logic r, input logic [19:0] a,
                      input logic [31:0] d, output logic [31:0] q);
      req_wr   = w;
      req_rd   = r;
      req_addr = a;
      req_data = d;
      @(negedge clk);
      req_wr = 1'b0;
      req_rd = 1'b0;
      check("ack", 64'(resp_ack), 64'd1);
      q = resp_data;
   endtask

   task automatic wr(input logic [19:0] a, input logic [31:0] d);
      logic [31:0] q;
      bus(1'b1, 1'b0, a, d, q);
      check("wr_resp_data", 64'(q), 64'd0);
   endtask

   task automatic rd_chk(input string tag, input logic [19:0] a, input logic [31:0] exp);
      logic [31:0] q;
      bus(1'b0, 1'b1, a, 32'd0, q);
      check(tag, 64'(q), 64'(exp));
   endtask

   task automatic idle();
      @(negedge clk);
   endtask

   initial begin
      rst_n    = 1'b0;
      req_wr   = 1'b0;
      req_rd   = 1'b0;
      req_addr = '0;
      req_data = '0;
      ts_ready = 2'b00;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_ack",      64'(resp_ack),    64'd0);
      check("rst_rdata",    64'(resp_data),   64'd0);
      check("rst_tx_start", 64'(tx_start),    64'd0);
      check("rst_tx_stop",  64'(tx_stop),     64'd0);
      check("rst_policy",   64'(stop_policy), 64'd0);
      check("rst_ts_valid", 64'(ts_valid),    64'd0);
      check("rst_ts_data",  ts_data[63:0] | ts_data[127:64], 64'd0);
      rst_n = 1'b1;
      idle();

      // Status and policy after reset
      rd_chk("sts_ch1_reset", 20'h90, 32'h0020_0000);
      rd_chk("pol_ch1_reset", 20'h8C, 32'h0);
      rd_chk("ovf_ch0_reset", 20'h58, 32'h0);

      // Single push, visible the cycle after the TS_HIGH write, then popped
      wr(20'h44, 32'h1122_3344);
      wr(20'h48, 32'h5566_7788);
      check("push1_valid", 64'(ts_valid), 64'h1);
      check("push1_data0", ts_data[63:0], 64'h5566_7788_1122_3344);
      check("push1_data1", ts_data[127:64], 64'h0);
      rd_chk("push1_fill", 20'h50, 32'h0020_0001);
      ts_ready = 2'b01;
      idle();
      ts_ready = 2'b00;
      check("pop1_valid", 64'(ts_valid), 64'h0);
      rd_chk("pop1_fill", 20'h50, 32'h0020_0000);

      // Overfill by one: 32 stored, one counted as overflow
      for (int i = 0; i < 33; i++) wr(20'h48, 32'(i));
      rd_chk("full_fill", 20'h50, 32'h0020_0020);
      rd_chk("full_ovf", 20'h58, 32'h1);
      check("full_head", ts_data[63:0], 64'h0000_0000_1122_3344);
      wr(20'h58, 32'h1234_5678);
      rd_chk("ovf_cleared", 20'h58, 32'h0);

      // Push into a full queue while popping is accepted
      ts_ready = 2'b01;
      wr(20'h48, 32'hAA);
      ts_ready = 2'b00;
      rd_chk("fullpop_fill", 20'h50, 32'h0020_0020);
      rd_chk("fullpop_ovf", 20'h58, 32'h0);
      check("fullpop_head", ts_data[63:0], 64'h0000_0001_1122_3344);

      // Flush
      wr(20'h54, 32'h1);
      check("flush_valid", 64'(ts_valid), 64'h0);
      rd_chk("flush_fill", 20'h50, 32'h0020_0000);

      // Flush with a simultaneous pop
      wr(20'h48, 32'h1);
      wr(20'h48, 32'h2);
      ts_ready = 2'b01;
      wr(20'h54, 32'h1);
      ts_ready = 2'b00;
      check("flushpop_valid", 64'(ts_valid), 64'h0);
      rd_chk("flushpop_fill", 20'h50, 32'h0020_0000);

      // TX_CTRL on channel 1: stop wins over start
      wr(20'h80, 32'h3);
      check("both_stop",  64'(tx_stop),  64'b10);
      check("both_start", 64'(tx_start), 64'b00);
      idle();
      check("both_stop_end", 64'(tx_stop), 64'b00);
      wr(20'h80, 32'h1);
      check("start_pulse", 64'(tx_start), 64'b10);
      check("start_nostop", 64'(tx_stop), 64'b00);
      idle();
      check("start_end", 64'(tx_start), 64'b00);

      // Fill 4, then push and flush back-to-back
      for (int i = 0; i < 4; i++) wr(20'h48, 32'(i + 100));
      rd_chk("fill4", 20'h50, 32'h0020_0004);
      wr(20'h48, 32'hDEAD);
      wr(20'h54, 32'h1);
      check("b2b_valid", 64'(ts_valid), 64'h0);
      rd_chk("b2b_fill", 20'h50, 32'h0020_0000);
      rd_chk("b2b_ovf", 20'h58, 32'h0);

      // Stop policy and decode boundaries
      wr(20'h8C, 32'hFFFF_FFFF);
      rd_chk("pol_ch1", 20'h8C, 32'h1);
      check("pol_out", 64'(stop_policy), 64'b10);
      rd_chk("pol_ch0", 20'h4C, 32'h0);
      wr(20'hCC, 32'h1);
      check("pol_past_end", 64'(stop_policy), 64'b10);
      rd_chk("rd_past_end", 20'hC0, 32'h0);
      rd_chk("rd_below_base", 20'h3C, 32'h0);
      rd_chk("rd_unmapped", 20'h01000, 32'h0);
      rd_chk("rd_wo_tslow", 20'h44, 32'h0);

      // Reset in the middle of a pending ack with a queued entry
      wr(20'h84, 32'hCAFE_0000);
      wr(20'h88, 32'h0000_BEEF);
      check("ch1_valid", 64'(ts_valid), 64'b10);
      check("ch1_data", ts_data[127:64], 64'h0000_BEEF_CAFE_0000);
      req_rd   = 1'b1;
      req_addr = 20'h90;
      @(posedge clk);
      #1;
      req_rd = 1'b0;
      check("pre_rst_ack", 64'(resp_ack), 64'd1);
      rst_n = 1'b0;
      #1;
      check("midrst_ack",    64'(resp_ack),    64'd0);
      check("midrst_valid",  64'(ts_valid),    64'd0);
      check("midrst_policy", 64'(stop_policy), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      idle();
      rd_chk("post_rst_fill", 20'h90, 32'h0020_0000);
      rd_chk("post_rst_pol", 20'h8C, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
